// File: rtl/mem_if_pkg.sv
// Shared main-memory interface constants and fetch FSM state type.
// Imported by the fetch unit and its prefetch buffer.
package mem_if_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [31:0] RESET_PC_DEF = 32'h0100_0000;
  localparam int          WORD_BYTES   = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FULL
  } fetch_state_e;

  function automatic logic misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {pc, data} entries between fetch and decode.
// Flush empties it in one edge; reset wins over flush.
module fetch_buffer
  import mem_if_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [31:0]       wr_data,
  output logic [ADDR_W-1:0] head_pc,
  output logic [31:0]       head_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_pc   = pc_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) begin
      pc_q[wr_ptr]   <= wr_pc;
      data_q[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Sequential instruction fetcher driving main-memory reads.
// Tags words with their PC and buffers them toward decode.
module inst_fetch_unit
  import mem_if_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int              DEPTH    = 2,
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_write,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [31:0]       inst_data,
  output logic              misalign_err
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic              pop;
  logic              push;
  logic              will_fill;

  assign inst_valid = !buf_empty;

  // A redirect discards anything decode would have taken.
  assign pop  = inst_valid && inst_ready && !redirect_valid;
  assign push = (state_q == RUN) && enable && !redirect_valid
             && (!buf_full || pop);

  assign will_fill =
      (buf_count == CW'(DEPTH - 1) && push && !pop)
   || (buf_full && !pop);

  assign mem_address    = fetch_pc;
  assign mem_read_write = READ;
  assign mem_data_in    = '0;

  fetch_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .wr_pc     (fetch_pc),
    .wr_data   (mem_data_out),
    .head_pc   (inst_pc),
    .head_data (inst_data),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Fetch FSM state register.
  always_ff @(posedge clock) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; redirect overrides normal flow.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = enable ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable)
            state_d = RUN;
        end
        RUN: begin
          if (!enable)
            state_d = IDLE;
          else if (will_fill)
            state_d = FULL;
        end
        FULL: begin
          if (!enable)
            state_d = IDLE;
          else if (pop)
            state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Fetch PC: restart on redirect, step one word per push.
  always_ff @(posedge clock) begin
    if (reset)
      fetch_pc <= RESET_PC;
    else if (redirect_valid)
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (push)
      fetch_pc <= fetch_pc + ADDR_W'(WORD_BYTES);
  end

  // Sticky flag for a redirect target off a word boundary.
  always_ff @(posedge clock) begin
    if (reset)
      misalign_err <= 1'b0;
    else if (redirect_valid && misaligned(redirect_pc[1:0]))
      misalign_err <= 1'b1;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit.
// Memory model returns fixed words keyed by address.
module tb_inst_fetch_unit;
  import mem_if_pkg::*;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0100_0000),
    .DEPTH    (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .mem_address    (mem_address),
    .mem_read_write (mem_read_write),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .misalign_err   (misalign_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0100_0000: return 32'h1111_1111;
      32'h0100_0004: return 32'h2222_2222;
      32'h0100_0008: return 32'h3333_3333;
      32'h0100_000C: return 32'h4444_4444;
      default:       return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  assign mem_data_out = mem_word(mem_address);

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic head_is(input string tag,
                         input logic [31:0] pc,
                         input logic [31:0] data);
    check({tag, ".valid"}, 64'(inst_valid), 64'(1));
    check({tag, ".head"}, {inst_pc, inst_data}, {pc, data});
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step(2);
    reset = 1'b0;

    check("rst.valid", 64'(inst_valid), 64'(0));
    check("rst.addr", 64'(mem_address), 64'h0100_0000);
    check("rst.misalign", 64'(misalign_err), 64'(0));
    check("rst.rw", 64'(mem_read_write), 64'(0));
    check("rst.din", 64'(mem_data_in), 64'(0));
    check("rst.state", 64'(dut.state_q), 64'(IDLE));

    // streaming with decode always ready
    enable     = 1'b1;
    inst_ready = 1'b1;
    step();
    check("lat.valid0", 64'(inst_valid), 64'(0));
    step();
    head_is("s0", 32'h0100_0000, 32'h1111_1111);
    step();
    head_is("s1", 32'h0100_0004, 32'h2222_2222);
    step();
    head_is("s2", 32'h0100_0008, 32'h3333_3333);
    check("s2.rw", 64'(mem_read_write), 64'(0));
    step();
    head_is("s3", 32'h0100_000C, 32'h4444_4444);

    // back-pressure from a fresh reset
    reset = 1'b1;
    step();
    reset      = 1'b0;
    inst_ready = 1'b0;
    step();
    check("bp.valid0", 64'(inst_valid), 64'(0));
    step();
    head_is("bp.first", 32'h0100_0000, 32'h1111_1111);
    step(5);
    check("bp.state", 64'(dut.state_q), 64'(FULL));
    check("bp.count", 64'(dut.buf_count), 64'(2));
    head_is("bp.hold", 32'h0100_0000, 32'h1111_1111);
    check("bp.addr", 64'(mem_address), 64'h0100_0008);

    inst_ready = 1'b1;
    step();
    head_is("rel0", 32'h0100_0004, 32'h2222_2222);
    check("rel0.state", 64'(dut.state_q), 64'(RUN));
    step();
    head_is("rel1", 32'h0100_0008, 32'h3333_3333);

    // refill, then redirect while full with decode ready
    inst_ready = 1'b0;
    step();
    check("refill.state", 64'(dut.state_q), 64'(FULL));
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0008;
    step();
    redirect_valid = 1'b0;
    check("rd.flush", 64'(inst_valid), 64'(0));
    check("rd.addr", 64'(mem_address), 64'h0100_0008);
    step();
    head_is("rd.first", 32'h0100_0008, 32'h3333_3333);
    check("rd.misalign", 64'(misalign_err), 64'(0));

    // misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_000E;
    step();
    redirect_valid = 1'b0;
    check("mis.flag", 64'(misalign_err), 64'(1));
    check("mis.addr", 64'(mem_address), 64'h0100_000C);
    step();
    head_is("mis.first", 32'h0100_000C, 32'h4444_4444);
    step();
    head_is("mis.next", 32'h0100_0010, 32'h0010_C0DE);
    check("mis.sticky", 64'(misalign_err), 64'(1));

    // reset beats a same-edge redirect with one entry buffered
    check("pre.count", 64'(dut.buf_count), 64'(1));
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0020;
    step();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    check("rr.valid", 64'(inst_valid), 64'(0));
    check("rr.addr", 64'(mem_address), 64'h0100_0000);
    check("rr.state", 64'(dut.state_q), 64'(IDLE));
    check("rr.misalign", 64'(misalign_err), 64'(0));

    // enable drops with two buffered entries
    inst_ready = 1'b0;
    step(3);
    check("en.count", 64'(dut.buf_count), 64'(2));
    enable     = 1'b0;
    inst_ready = 1'b1;
    head_is("dr0", 32'h0100_0000, 32'h1111_1111);
    step();
    head_is("dr1", 32'h0100_0004, 32'h2222_2222);
    step();
    check("dr.empty", 64'(inst_valid), 64'(0));
    check("dr.addr", 64'(mem_address), 64'h0100_0008);
    step(2);
    check("dr.frozen", 64'(mem_address), 64'h0100_0008);
    enable = 1'b1;
    step();
    check("re.valid0", 64'(inst_valid), 64'(0));
    step();
    head_is("re.first", 32'h0100_0008, 32'h3333_3333);

    // PC wrap at top of address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    head_is("wrap0", 32'hFFFF_FFFC, 32'hFFFC_C0DE);
    step();
    head_is("wrap1", 32'h0000_0000, 32'h0000_C0DE);
    check("wrap.rw", 64'(mem_read_write), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
